// File: rtl/alu_branch_pkg.sv
// Shared encodings for alu_branch_ctrl: ALU control codes, alu_op/branch funct3
// encodings and the 2-bit saturating prediction counter.
package alu_branch_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

  typedef enum logic [1:0] {
    AOP_ADD    = 2'b00,
    AOP_BRANCH = 2'b01,
    AOP_RI     = 2'b10,
    AOP_RSVD   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t CTR_RESET = 2'b01;

  function automatic bht_ctr_t ctr_inc(input bht_ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic bht_ctr_t ctr_dec(input bht_ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic bht_ctr_t ctr_update(input bht_ctr_t c, input logic taken);
    return taken ? ctr_inc(c) : ctr_dec(c);
  endfunction

endpackage

// File: rtl/alu_branch_ctrl_bht.sv
// branch_hist_table: array of 2-bit saturating counters, one combinational read
// port and one synchronous update port; async reset to weakly not-taken.
module branch_hist_table
  import alu_branch_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(BHT_DEPTH)-1:0] rd_idx_i,
  output bht_ctr_t                     rd_ctr_o,
  input  logic                         upd_en_i,
  input  logic [$clog2(BHT_DEPTH)-1:0] upd_idx_i,
  input  logic                         upd_taken_i
);

  bht_ctr_t ctr_q [BHT_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_update(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/alu_branch_ctrl.sv
// alu_branch_ctrl: registered ALU-control decode plus single-outstanding branch
// resolve. Define ALU_BRANCH_CTRL_BHT_EN to enable the 2-bit counter predictor.
module alu_branch_ctrl
  import alu_branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CTRL_W    = ALU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [XLEN-1:0]   pc,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              op5,
  input  logic              branch,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              ctrl_valid,
  output logic              pred_taken,
  output logic              illegal,
  input  logic              res_valid,
  input  logic              zero_f,
  input  logic              neg_f,
  input  logic              carry_f,
  input  logic              ovf_f,
  output logic              res_done,
  output logic              pc_src,
  output logic              mispredict
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic              pending_q, pending_d;
  logic [2:0]        pend_f3_q, pend_f3_d;
  logic              pend_pred_q, pend_pred_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic              illegal_q, illegal_d;
  logic              pred_taken_q, pred_taken_d;
  logic              res_done_q, res_done_d;
  logic              pc_src_q, pc_src_d;
  logic              mispredict_q, mispredict_d;

  logic              accept, resolve, br_accept;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              taken;
  logic              pred_rd;
  logic              unused_pc;

  assign dec_ready = ~pending_q | (res_valid & pending_q);
  assign accept    = dec_valid & dec_ready & ~kill;
  assign resolve   = res_valid & pending_q & ~kill;
  assign br_accept = accept & (alu_op_e'(alu_op) == AOP_BRANCH) & branch;

  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    case (alu_op_e'(alu_op))
      AOP_ADD:    dec_ctrl = ALU_ADD;
      AOP_BRANCH: begin
        dec_ctrl    = ALU_SUB;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      AOP_RI: begin
        case (funct3)
          3'b000:  dec_ctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_ctrl = ALU_SLL;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b011:  dec_ctrl = ALU_SLTU;
          3'b100:  dec_ctrl = ALU_XOR;
          3'b101:  dec_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_ctrl = ALU_OR;
          default: dec_ctrl = ALU_AND;
        endcase
      end
      default: begin
        dec_ctrl    = ALU_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Unsupported branch funct3 (010/011) falls to default and resolves not-taken.
  always_comb begin
    taken = 1'b0;
    case (pend_f3_q)
      F3_BEQ:  taken = zero_f;
      F3_BNE:  taken = ~zero_f;
      F3_BLT:  taken = neg_f ^ ovf_f;
      F3_BGE:  taken = ~(neg_f ^ ovf_f);
      F3_BLTU: taken = ~carry_f;
      F3_BGEU: taken = carry_f;
      default: taken = 1'b0;
    endcase
  end

`ifdef ALU_BRANCH_CTRL_BHT_EN
  logic [IDX_W-1:0] pend_idx_q;
  bht_ctr_t         rd_ctr;

  // Read happens before the same-edge update, so a back-to-back accept sees the old counter.
  branch_hist_table #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (pc[IDX_W+1:2]),
    .rd_ctr_o    (rd_ctr),
    .upd_en_i    (resolve),
    .upd_idx_i   (pend_idx_q),
    .upd_taken_i (taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pend_idx_q <= '0;
    else if (br_accept) pend_idx_q <= pc[IDX_W+1:2];
  end

  assign pred_rd   = rd_ctr[1];
  assign unused_pc = ^{pc[XLEN-1:IDX_W+2], pc[1:0]};
`else
  assign pred_rd   = 1'b0;
  assign unused_pc = ^pc;
`endif

  always_comb begin
    pending_d    = pending_q;
    pend_f3_d    = pend_f3_q;
    pend_pred_d  = pend_pred_q;
    alu_ctrl_d   = alu_ctrl_q;
    illegal_d    = illegal_q;
    pred_taken_d = pred_taken_q;
    pc_src_d     = pc_src_q;
    mispredict_d = mispredict_q;
    ctrl_valid_d = accept;
    res_done_d   = resolve;
    if (accept) begin
      alu_ctrl_d   = dec_ctrl;
      illegal_d    = dec_illegal;
      pred_taken_d = br_accept & pred_rd;
    end
    if (resolve) begin
      pc_src_d     = taken;
      mispredict_d = taken ^ pend_pred_q;
      pending_d    = 1'b0;
    end
    if (br_accept) begin
      pending_d   = 1'b1;
      pend_f3_d   = funct3;
      pend_pred_d = pred_rd;
    end
    if (kill) begin
      pending_d    = 1'b0;
      pc_src_d     = 1'b0;
      mispredict_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      pend_f3_q    <= '0;
      pend_pred_q  <= 1'b0;
      alu_ctrl_q   <= '0;
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      pred_taken_q <= 1'b0;
      res_done_q   <= 1'b0;
      pc_src_q     <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      pend_f3_q    <= pend_f3_d;
      pend_pred_q  <= pend_pred_d;
      alu_ctrl_q   <= alu_ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      illegal_q    <= illegal_d;
      pred_taken_q <= pred_taken_d;
      res_done_q   <= res_done_d;
      pc_src_q     <= pc_src_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign alu_ctrl   = alu_ctrl_q;
  assign ctrl_valid = ctrl_valid_q;
  assign illegal    = illegal_q;
  assign pred_taken = pred_taken_q;
  assign res_done   = res_done_q;
  assign pc_src     = pc_src_q;
  assign mispredict = mispredict_q;

endmodule

// File: doc/alu_branch_ctrl.md
Name: alu_branch_ctrl

Overview:
- Parametrised successor to the single-cycle ALU decoder, for the pipelined core.
- Decode half: registers a 4-bit ALU control, adding SRA/SLT/SLTU to the existing opcodes.
- Resolve half: resolves all six RV32I branch conditions from ALU flags that arrive one or more cycles after decode.
- Holds one outstanding branch and a table of 2-bit saturating counters for taken/not-taken prediction; it sits between the instruction decoder and the fetch PC mux.

Parameters:
- XLEN, 32, PC width.
- BHT_DEPTH, 16, counter-table entries; power of two, minimum 2.
- CTRL_W, 4, ALU control width; fixed at 4, present for package consistency.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- kill  in  1  flush; drops the pending branch and ctrl_valid.
- dec_valid  in  1  decode request.
- dec_ready  out  1  request accepted when dec_valid & dec_ready.
- pc  in  XLEN  PC of decoded instruction.
- alu_op  in  2  00 = add, 01 = branch, 10 = R/I-type, 11 = reserved.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- op5  in  1  opcode bit 5 (R-type).
- branch  in  1  instruction is a conditional branch.
- alu_ctrl  out  CTRL_W  registered ALU control.
- ctrl_valid  out  1  alu_ctrl/pred_taken valid (one-cycle pulse per accept).
- pred_taken  out  1  prediction for the accepted branch.
- illegal  out  1  registered; unsupported funct3/alu_op.
- res_valid  in  1  flags for the pending branch are valid.
- zero_f, neg_f, carry_f, ovf_f  in  1 each  ALU flags from SUB; carry_f = 1 means no borrow.
- res_done  out  1  one-cycle pulse, resolve complete.
- pc_src  out  1  branch actually taken.
- mispredict  out  1  pc_src != prediction made at decode.

Behaviour:
- Reset: all outputs 0 except dec_ready = 1; pending = 0; every counter = 2'b01 (weakly not-taken).
- dec_ready = ~pending | (res_valid & pending); combinational.
- Accept at edge N → alu_ctrl, ctrl_valid, illegal, pred_taken valid at N+1. Latency is 1 cycle, with no input-to-output combinational path except dec_ready.
- ALU control codes:
  - ADD 0000, SLL 0001, SUB 0010, XOR 0100, SRL 0101, OR 0110, AND 0111.
  - SRA 1101, SLT 1011, SLTU 1100.
- alu_op = 00 → ADD.
- alu_op = 01 → SUB.
  - funct3 010/011 → illegal = 1; the branch is recorded, resolves not-taken, and mispredicts if predicted taken.
- alu_op = 10:
  - f3 000 → SUB if op5 & funct7b5, else ADD.
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - 101 → SRA if funct7b5, else SRL.
  - 110 → OR; 111 → AND.
- alu_op = 11 → ADD, illegal = 1.
- Branch accept (alu_op = 01 & branch):
  - Sets pending and stores funct3 and index = pc[$clog2(BHT_DEPTH)+1:2].
  - pred_taken = counter[index][1].
- Resolve (res_valid & pending) at edge M; at M+1: res_done = 1, pc_src, mispredict. Taken conditions by funct3:
  - 000 zero_f; 001 ~zero_f.
  - 100 neg_f^ovf_f; 101 ~(neg_f^ovf_f).
  - 110 ~carry_f; 111 carry_f.
- Counter update at edge M: increment if taken, decrement if not; saturates at 00 and 11. Pending clears unless a new branch is accepted at the same edge.
- Same-cycle resolve + new accept to the same index: prediction reads the pre-update counter.
- res_valid with no pending: ignored, no res_done.
- kill: at the next edge clears pending, ctrl_valid, res_done, pc_src, mispredict; no counter update; kill beats simultaneous accept/resolve. Counters are retained.
- Mid-operation rst: immediate return to reset state, including the counter table.
- Non-branch accepts never touch pending or counters; pred_taken = 0.

Optional Feature:
- ALU_BRANCH_CTRL_BHT_EN defined: counter table as above.
- Undefined: no table storage, pred_taken always 0 (static not-taken), mispredict = pc_src; all other behaviour identical.

Decomposition:
- Package alu_branch_pkg holds:
  - ALU control localparams.
  - alu_op and branch funct3 encodings.
  - 2-bit counter type with reset value and saturating inc/dec functions.
- Sub-module branch_hist_table (BHT_DEPTH parameter) holds the counter array with async-reset init:
  - one combinational read port;
  - one synchronous update port.
  - It is instantiated only under ALU_BRANCH_CTRL_BHT_EN.

Test Plan:
- Reset, then R-type sweep: f3 000 with op5 = 1, funct7b5 = 1 → 0010; f3 101 with funct7b5 = 1 → 1101; f3 011 → 1100; each ctrl_valid one cycle after accept.
- BEQ at pc 0x40, first ever → pred_taken = 0; res_valid with zero_f = 1 → pc_src = 1, mispredict = 1; counter[0] 01 → 10; a second BEQ at 0x40 → pred_taken = 1.
- BLTU: carry_f = 0 → taken. BGE: neg_f = 1, ovf_f = 1 → taken. BNE with zero_f = 1 → not taken; each res_done pulses exactly once.
- Pending branch with dec_valid held and no res_valid → dec_ready = 0 for 5 cycles. Then res_valid together with a new BEQ at the same index → new accept in the same cycle, pred_taken from the old counter value.
- kill asserted alongside res_valid → no res_done, counter unchanged, dec_ready = 1 next cycle.
- Five taken resolves on one index → counter saturates at 11; rst mid-stream → all counters 01 and outputs 0. With macro undefined → pred_taken is never 1.
